// File: rtl/fila_pkg.sv
// fila_pkg - shared constants and types for the queue user-side controller.
//   WIDTH            data byte width, must match the queue
//   DEPTH            queue capacity (full threshold)
//   LEN_W            width of the queue occupancy count, holds 0..DEPTH
//   DEBOUNCE_CYCLES  default stable-sample count for button filtering
//   fila_ctrl_state_t controller FSM states
package fila_pkg;

    localparam int WIDTH           = 8;
    localparam int DEPTH           = 8;
    localparam int LEN_W           = $clog2(DEPTH + 1);
    localparam int DEBOUNCE_CYCLES = 100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENQ     = 2'd1,
        DEQ     = 2'd2,
        CAPTURE = 2'd3
    } fila_ctrl_state_t;

endpackage

// File: rtl/fila_ctrl_if.sv
// fila_ctrl_if - link between the controller and the 8x8 queue.
//   enqueue_out  one-cycle enqueue strobe (controller -> queue)
//   dequeue_out  one-cycle dequeue strobe (controller -> queue)
//   data_out     byte for the queue's data_in (controller -> queue)
//   q_len        queue occupancy, the queue's len_out (queue -> controller)
//   q_data       queue head byte, the queue's data_out (queue -> controller)
// Modports: master = controller side, slave = queue side.
interface fila_ctrl_if
    import fila_pkg::*;
#(
    parameter int WIDTH = fila_pkg::WIDTH,
    parameter int LEN_W = fila_pkg::LEN_W
);
    logic             enqueue_out;
    logic             dequeue_out;
    logic [WIDTH-1:0] data_out;
    logic [LEN_W-1:0] q_len;
    logic [WIDTH-1:0] q_data;

    modport master (
        output enqueue_out,
        output dequeue_out,
        output data_out,
        input  q_len,
        input  q_data
    );

    modport slave (
        input  enqueue_out,
        input  dequeue_out,
        input  data_out,
        output q_len,
        output q_data
    );
endinterface

// File: rtl/fila_ctrl_btn_press.sv
// btn_press - turns a raw asynchronous push-button into a one-cycle press pulse.
//   clk_10KHz  system clock
//   reset      asynchronous active-high reset
//   btn_raw    raw button level, asynchronous to clk_10KHz
//   press      one-cycle pulse per accepted 0->1 transition
// Path: 2-flop synchronizer -> optional debounce filter -> rising-edge detector.
// Macro FILA_DEBOUNCE_EN inserts the debounce filter (latency DEBOUNCE_CYCLES+3);
// without it the latency is 3 cycles and bounces give multiple presses.
module btn_press #(
    parameter int DEBOUNCE_CYCLES = 100
) (
    input  logic clk_10KHz,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    logic sync_1;
    logic sync_2;
    logic level;
    logic level_d;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_press: DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

`ifdef FILA_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Down-counter reloads whenever the synchronized input agrees with the
    // filtered level; only DEBOUNCE_CYCLES consecutive disagreeing samples
    // reach terminal count and move the filtered level.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= RELOAD;
        end else if (sync_2 == level) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            level <= sync_2;
            cnt   <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
`else
    assign level = sync_2;
`endif

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end
endmodule

// File: rtl/fila_ctrl.sv
// fila_ctrl - user-side controller for the 8x8-bit queue (fila).
//   clk_10KHz    system clock
//   reset        asynchronous active-high reset
//   btn_enq      raw enqueue button
//   btn_deq      raw dequeue button
//   sw_data      switch value to enqueue
//   q            fila_ctrl_if.master: enqueue_out/dequeue_out/data_out to the
//                queue, q_len/q_data from the queue
//   shown_data   last byte dequeued
//   shown_valid  shown_data holds a real dequeued byte
//   err_full     last request was an enqueue rejected on a full queue
//   err_empty    last request was a dequeue rejected on an empty queue
// Macro FILA_DEBOUNCE_EN enables button debouncing inside btn_press.
//
// state   | meaning
// IDLE    | waiting for a press; full/empty checks happen here
// ENQ     | enqueue_out high for one cycle, data_out = sampled sw_data
// DEQ     | dequeue_out high for one cycle
// CAPTURE | queue head now shows the popped byte; latch it for display
module fila_ctrl
    import fila_pkg::*;
#(
    parameter int WIDTH           = fila_pkg::WIDTH,
    parameter int DEPTH           = fila_pkg::DEPTH,
    parameter int LEN_W           = fila_pkg::LEN_W,
    parameter int DEBOUNCE_CYCLES = fila_pkg::DEBOUNCE_CYCLES
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic             btn_enq,
    input  logic             btn_deq,
    input  logic [WIDTH-1:0] sw_data,
    fila_ctrl_if.master      q,
    output logic [WIDTH-1:0] shown_data,
    output logic             shown_valid,
    output logic             err_full,
    output logic             err_empty
);
    if ((1 << LEN_W) <= DEPTH) begin : g_bad_len_w
        $error("fila_ctrl: LEN_W too narrow to hold DEPTH");
    end

    fila_ctrl_state_t state;

    logic             press_enq;
    logic             press_deq;
    logic             enq_r;
    logic             deq_r;
    logic [WIDTH-1:0] data_r;
    logic             q_full;
    logic             q_empty;

    btn_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_press_enq (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .btn_raw   (btn_enq),
        .press     (press_enq)
    );

    btn_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_press_deq (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .btn_raw   (btn_deq),
        .press     (press_deq)
    );

    // Occupancy above DEPTH can only be a glitch on the queue side; treat as full.
    assign q_full  = (q.q_len >= LEN_W'(DEPTH));
    assign q_empty = (q.q_len == '0);

    assign q.enqueue_out = enq_r;
    assign q.dequeue_out = deq_r;
    assign q.data_out    = data_r;

    // Strobes are set on entry to ENQ/DEQ so they line up with the state, and
    // every operation returns through IDLE so q_len has settled before the
    // next full/empty decision.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            enq_r       <= 1'b0;
            deq_r       <= 1'b0;
            data_r      <= '0;
            shown_data  <= '0;
            shown_valid <= 1'b0;
            err_full    <= 1'b0;
            err_empty   <= 1'b0;
        end else begin
            enq_r <= 1'b0;
            deq_r <= 1'b0;
            case (state)
                IDLE: begin
                    // Enqueue wins a simultaneous press, matching the queue.
                    if (press_enq) begin
                        if (q_full) begin
                            err_full  <= 1'b1;
                            err_empty <= 1'b0;
                        end else begin
                            state     <= ENQ;
                            enq_r     <= 1'b1;
                            data_r    <= sw_data;
                            err_full  <= 1'b0;
                            err_empty <= 1'b0;
                        end
                    end else if (press_deq) begin
                        if (q_empty) begin
                            err_empty <= 1'b1;
                            err_full  <= 1'b0;
                        end else begin
                            state     <= DEQ;
                            deq_r     <= 1'b1;
                            err_full  <= 1'b0;
                            err_empty <= 1'b0;
                        end
                    end
                end
                ENQ: begin
                    state <= IDLE;
                end
                DEQ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    shown_data  <= q.q_data;
                    shown_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
